// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state type and default constants for the RC4 PRGA decrypt engine.
package rc4_pkg;
    localparam int         RC4_DATA_W  = 8;
    localparam logic [7:0] RC4_CHAR_LO = 8'h61;
    localparam logic [7:0] RC4_CHAR_HI = 8'h7A;
    localparam logic [7:0] RC4_CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WT_SI,
        RD_SJ,
        WT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WT_F,
        WR_OUT,
        NEXT,
        DONE
    } state_e;
endpackage

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext legality predicate.
//   char_i  : candidate plaintext symbol
//   legal_o : 1 when CHAR_LO <= char_i <= CHAR_HI or char_i == CHAR_SP
module rc4_char_check
    import rc4_pkg::*;
#(
    parameter int                DATA_W  = RC4_DATA_W,
    parameter logic [DATA_W-1:0] CHAR_LO = DATA_W'(RC4_CHAR_LO),
    parameter logic [DATA_W-1:0] CHAR_HI = DATA_W'(RC4_CHAR_HI),
    parameter logic [DATA_W-1:0] CHAR_SP = DATA_W'(RC4_CHAR_SP)
) (
    input  logic [DATA_W-1:0] char_i,
    output logic              legal_o
);
    assign legal_o = (char_i >= CHAR_LO && char_i <= CHAR_HI) || char_i == CHAR_SP;
endmodule

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 keystream generation over a pre-initialised S RAM, XOR with ciphertext, plaintext out.
//   clk, reset               : clock, synchronous active-high reset
//   start                    : begin a pass (honoured only in IDLE or DONE)
//   busy, done               : pass in progress / pass finished
//   valid_msg, abort         : DONE result, all bytes legal / stopped on an illegal byte
//   s_addr/s_wdata/s_we      : S RAM port, s_rdata returns one cycle after the address
//   msg_addr/msg_rdata       : ciphertext ROM, one cycle latency
//   out_addr/out_wdata/out_we: plaintext RAM write port
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int                DATA_W   = RC4_DATA_W,
    parameter int                MSG_LEN  = 32,
    parameter int                MSG_AW   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    parameter bit                CHECK_EN = 1'b1,
    parameter logic [DATA_W-1:0] CHAR_LO  = DATA_W'(RC4_CHAR_LO),
    parameter logic [DATA_W-1:0] CHAR_HI  = DATA_W'(RC4_CHAR_HI),
    parameter logic [DATA_W-1:0] CHAR_SP  = DATA_W'(RC4_CHAR_SP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              valid_msg,
    output logic              abort,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [MSG_AW-1:0] msg_addr,
    input  logic [DATA_W-1:0] msg_rdata,
    output logic [MSG_AW-1:0] out_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_we
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              bad_q, bad_d;
    logic              legal;
    logic [DATA_W-1:0] pt;

    assign pt = f_q ^ c_q;

    rc4_char_check #(
        .DATA_W (DATA_W),
        .CHAR_LO(CHAR_LO),
        .CHAR_HI(CHAR_HI),
        .CHAR_SP(CHAR_SP)
    ) u_char_check (
        .char_i (pt),
        .legal_o(legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            c_q     <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            c_q     <= c_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        c_d     = c_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_SI;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    bad_d   = 1'b0;
                end
            end
            RD_SI: begin
                i_d     = i_q + DATA_W'(1);
                state_d = WT_SI;
            end
            WT_SI: begin
                si_d    = s_rdata;
                j_d     = j_q + s_rdata;
                state_d = RD_SJ;
            end
            RD_SJ:  state_d = WT_SJ;
            WT_SJ: begin
                sj_d    = s_rdata;
                state_d = WR_SI;
            end
            WR_SI:  state_d = WR_SJ;
            WR_SJ:  state_d = RD_F;
            RD_F:   state_d = WT_F;
            WT_F: begin
                f_d     = s_rdata;
                c_d     = msg_rdata;
                state_d = WR_OUT;
            end
            WR_OUT: begin
                bad_d   = CHECK_EN && !legal;
                state_d = NEXT;
            end
            NEXT: begin
                if (bad_q || k_q == MSG_AW'(MSG_LEN - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = RD_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // i and j are distinct registers, so when i == j the WR_SJ write simply
    // overwrites WR_SI with the same value (si == sj).
    always_comb begin
        busy      = !(state_q inside {IDLE, DONE});
        done      = state_q == DONE;
        valid_msg = state_q == DONE && !bad_q;
        abort     = state_q == DONE && bad_q;
        s_addr    = '0;
        s_wdata   = '0;
        s_we      = 1'b0;
        msg_addr  = '0;
        out_addr  = '0;
        out_wdata = '0;
        out_we    = 1'b0;
        case (state_q)
            RD_SI:  s_addr = i_q + DATA_W'(1);
            RD_SJ:  s_addr = j_q;
            WR_SI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_we    = 1'b1;
            end
            WR_SJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_we    = 1'b1;
            end
            RD_F: begin
                s_addr   = si_q + sj_q;
                msg_addr = k_q;
            end
            WR_OUT: begin
                out_addr  = k_q;
                out_wdata = pt;
                out_we    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: three engine configurations checked against a plain RC4 reference model.
module tb_rc4_prga_decrypt;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start[3], load[3], busy[3], done[3], valid[3], abrt[3], s_we[3], out_we[3];
    logic [7:0] s_addr[3], s_wdata[3], s_rdata[3], msg_rdata[3], out_wdata[3];
    logic [8:0] msg_addr[3], out_addr[3];
    logic [1:0] ma0, ma1, oa0, oa1;
    logic [8:0] ma2, oa2;
    logic [7:0] s_mem[3][256], img_s[3][256], img_c[3][300], out_mem[3][300], exp_s[256];
    int         exp_q[$];
    int         exp_cnt, vec, err, cyc, cmp_e, wcnt[3];
    bit         exp_abort;

    assign msg_addr[0] = {7'd0, ma0};
    assign msg_addr[1] = {7'd0, ma1};
    assign msg_addr[2] = ma2;
    assign out_addr[0] = {7'd0, oa0};
    assign out_addr[1] = {7'd0, oa1};
    assign out_addr[2] = oa2;

    rc4_prga_decrypt #(.MSG_LEN(3), .CHECK_EN(1'b0)) u_a (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .valid_msg(valid[0]), .abort(abrt[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_we(s_we[0]), .s_rdata(s_rdata[0]), .msg_addr(ma0), .msg_rdata(msg_rdata[0]),
        .out_addr(oa0), .out_wdata(out_wdata[0]), .out_we(out_we[0]));
    rc4_prga_decrypt #(.MSG_LEN(3), .CHECK_EN(1'b1)) u_b (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .valid_msg(valid[1]), .abort(abrt[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_we(s_we[1]), .s_rdata(s_rdata[1]), .msg_addr(ma1), .msg_rdata(msg_rdata[1]),
        .out_addr(oa1), .out_wdata(out_wdata[1]), .out_we(out_we[1]));
    rc4_prga_decrypt #(.MSG_LEN(300), .CHECK_EN(1'b0)) u_c (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .valid_msg(valid[2]), .abort(abrt[2]), .s_addr(s_addr[2]), .s_wdata(s_wdata[2]),
        .s_we(s_we[2]), .s_rdata(s_rdata[2]), .msg_addr(ma2), .msg_rdata(msg_rdata[2]),
        .out_addr(oa2), .out_wdata(out_wdata[2]), .out_we(out_we[2]));

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (load[n] === 1'b1) begin
                for (int x = 0; x < 256; x++) s_mem[n][x] <= img_s[n][x];
            end else if (s_we[n] === 1'b1) begin
                s_mem[n][s_addr[n]] <= s_wdata[n];
            end
            s_rdata[n]   <= s_mem[n][s_addr[n]];
            msg_rdata[n] <= (msg_addr[n] < 9'd300) ? img_c[n][msg_addr[n]] : 8'h00;
            if (out_we[n] === 1'b1 && out_addr[n] < 9'd300) out_mem[n][out_addr[n]] <= out_wdata[n];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // every plaintext write is matched in order against the model's expected (instance, addr, data)
    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (out_we[n] === 1'b1) begin
                wcnt[n]++;
                if (exp_q.size() == 0) begin
                    chk("extra_out_write", n * 65536 + int'(out_addr[n]) * 256 + int'(out_wdata[n]), 32'hFFFF_FFFF);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("out_write", n * 65536 + int'(out_addr[n]) * 256 + int'(out_wdata[n]), cmp_e);
                end
            end
        end
    end

    task automatic model(input int n, input int len, input bit ce);
        logic [7:0] s[256];
        int i, j, t, p;
        bit bad;
        i = 0;
        j = 0;
        bad = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        for (int x = 0; x < 256; x++) s[x] = img_s[n][x];
        for (int k = 0; k < len && !bad; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = int'(s[i]);
            s[i] = s[j];
            s[j] = t[7:0];
            p = int'(s[(int'(s[i]) + int'(s[j])) % 256]) ^ int'(img_c[n][k]);
            exp_q.push_back(n * 65536 + k * 256 + p);
            bad = ce && !((p >= 'h61 && p <= 'h7A) || p == 'h20);
            exp_cnt++;
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
        exp_abort = bad;
    endtask

    task automatic load_img(input int n);
        @(negedge clk) load[n] = 1'b1;
        @(negedge clk) load[n] = 1'b0;
    endtask

    task automatic run(input int n, input int len, input bit ce, input int pulse_at);
        int m;
        model(n, len, ce);
        wcnt[n] = 0;
        @(negedge clk) start[n] = 1'b1;
        @(negedge clk) start[n] = 1'b0;
        chk("busy_after_start", busy[n], 1);
        chk("flags_cleared", {done[n], valid[n], abrt[n]}, 0);
        cyc = 0;
        while (done[n] !== 1'b1 && cyc < 4000) begin
            start[n] = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        start[n] = 1'b0;
        chk("done_latency", cyc, 10 * exp_cnt);
        chk("valid_msg", valid[n], !exp_abort);
        chk("abort", abrt[n], exp_abort);
        chk("busy_in_done", busy[n], 0);
        chk("missing_writes", exp_q.size(), 0);
        exp_q.delete();
        m = 0;
        for (int x = 0; x < 256; x++) if (s_mem[n][x] !== exp_s[x]) m++;
        chk("final_s_errors", m, 0);
    endtask

    task automatic chk_idle(input int n, input string tag);
        chk({tag, "_busy"}, busy[n], 0);
        chk({tag, "_done"}, {done[n], valid[n], abrt[n]}, 0);
        chk({tag, "_s_port"}, {s_addr[n], s_wdata[n], 7'd0, s_we[n]}, 0);
        chk({tag, "_msg_addr"}, msg_addr[n], 0);
        chk({tag, "_out_port"}, {out_addr[n], out_wdata[n], out_we[n]}, 0);
    endtask

    initial begin
        logic [7:0] t;
        int r;
        vec = 0;
        err = 0;
        for (int n = 0; n < 3; n++) begin
            start[n] = 1'b0;
            load[n] = 1'b0;
            wcnt[n] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 3; n++) chk_idle(n, "reset");
        reset = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) chk_idle(n, "post_reset");

        // identity S, zero ciphertext, no character check
        for (int x = 0; x < 256; x++) img_s[0][x] = 8'(x);
        for (int k = 0; k < 3; k++) img_c[0][k] = 8'h00;
        load_img(0);
        run(0, 3, 1'b0, -1);
        chk("ident_latency", cyc, 30);
        chk("ident_out", {out_mem[0][0], out_mem[0][1], out_mem[0][2]}, 24'h020507);
        chk("ident_s", {s_mem[0][2], s_mem[0][3], s_mem[0][5]}, 24'h030502);
        chk("ident_valid", valid[0], 1);

        // random permutation, 300 bytes so i wraps
        for (int x = 0; x < 256; x++) img_s[2][x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = img_s[2][x];
            img_s[2][x] = img_s[2][r];
            img_s[2][r] = t;
        end
        for (int k = 0; k < 300; k++) img_c[2][k] = 8'($urandom_range(255, 0));
        load_img(2);
        run(2, 300, 1'b0, -1);
        chk("wrap_latency", cyc, 3000);
        chk("wrap_writes", wcnt[2], 300);

        // legal message "aaa"
        for (int x = 0; x < 256; x++) img_s[1][x] = 8'(x);
        img_c[1][0] = 8'h63;
        img_c[1][1] = 8'h64;
        img_c[1][2] = 8'h66;
        load_img(1);
        run(1, 3, 1'b1, -1);
        chk("legal_out", {out_mem[1][0], out_mem[1][1], out_mem[1][2]}, 24'h616161);
        chk("legal_flags", {valid[1], abrt[1]}, 2'b10);

        // byte 1 decrypts to 05: abort after two writes
        img_c[1][1] = 8'h00;
        load_img(1);
        run(1, 3, 1'b1, -1);
        chk("abort_latency", cyc, 20);
        chk("abort_writes", wcnt[1], 2);
        chk("abort_flags", {valid[1], abrt[1]}, 2'b01);
        chk("abort_byte", out_mem[1][1], 8'h05);

        // restart from DONE(abort) with a stray start pulse while busy
        img_c[1][1] = 8'h64;
        load_img(1);
        run(1, 3, 1'b1, 5);
        chk("restart_latency", cyc, 30);
        chk("restart_writes", wcnt[1], 3);
        chk("restart_flags", {valid[1], abrt[1]}, 2'b10);

        // reset while the first swap write is on the bus
        load_img(1);
        model(1, 3, 1'b1);
        @(negedge clk) start[1] = 1'b1;
        @(negedge clk) start[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("wr_si_we", s_we[1], 1);
        chk("wr_si_addr", s_addr[1], 8'h01);
        reset = 1'b1;
        @(negedge clk);
        chk_idle(1, "mid_reset");
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_idle(1, "after_mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Full RC4 PRGA decrypt engine: generates the keystream by updating i/j and swapping in the shared S RAM, XORs it with the ciphertext ROM, and writes plaintext to an output RAM.
- Optional plaintext validity check aborts early on an illegal character so the key-search controller can advance to the next key quickly.
- Sits between the KSA stage (which leaves S initialised) and the key-search controller.

Parameters:
- DATA_W, 8, symbol width; S depth is 2**DATA_W.
- MSG_LEN, 32, number of message bytes (>=1).
- MSG_AW, $clog2(MSG_LEN), message/output address width.
- CHECK_EN, 1, 1 = enable the character check and early abort.
- CHAR_LO, 8'h61, lowest legal letter.
- CHAR_HI, 8'h7A, highest legal letter.
- CHAR_SP, 8'h20, additional legal character.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- valid_msg  out  1  in DONE: 1 = all bytes legal (or CHECK_EN=0).
- abort  out  1  in DONE: 1 = stopped on an illegal byte.
- s_addr  out  DATA_W  S RAM address.
- s_wdata  out  DATA_W  S RAM write data.
- s_we  out  1  S RAM write enable.
- s_rdata  in  DATA_W  S RAM read data; 1-cycle synchronous latency.
- msg_addr  out  MSG_AW  ciphertext ROM address.
- msg_rdata  in  DATA_W  ciphertext data; 1-cycle latency.
- out_addr  out  MSG_AW  plaintext RAM address.
- out_wdata  out  DATA_W  plaintext RAM write data.
- out_we  out  1  plaintext RAM write enable.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state=IDLE; i=j=k=0; all outputs 0; no writes are issued.
- Reset mid-operation: at the next edge the block enters IDLE with all outputs 0; a partially swapped S is acceptable.
- Outputs are Moore-decoded from the state and registers. Address/data outputs are 0 in states that do not use them.
- Arithmetic: i, j and the f-address wrap mod 2**DATA_W. k counts 0..MSG_LEN-1 and never wraps.
- Per-byte sequence, 10 cycles; all addresses are presented for one cycle:
  - RD_SI: i<=i+1; s_addr=i+1.
  - WT_SI: si<=s_rdata; j<=j+s_rdata.
  - RD_SJ: s_addr=j.
  - WT_SJ: sj<=s_rdata.
  - WR_SI: s_addr=i, s_wdata=sj, s_we=1.
  - WR_SJ: s_addr=j, s_wdata=si, s_we=1.
  - RD_F: s_addr=si+sj; msg_addr=k.
  - WT_F: f<=s_rdata; c<=msg_rdata.
  - WR_OUT: out_addr=k, out_wdata=f^c, out_we=1; evaluate legality of f^c; set bad flag if illegal and CHECK_EN=1.
  - NEXT: if bad -> DONE with abort=1; else if k==MSG_LEN-1 -> DONE with valid_msg=1; else k<=k+1 -> RD_SI.
- i==j: both swap writes target the same address; the second write wins, which is correct because si==sj.
- Legal character: CHAR_LO<=x<=CHAR_HI, or x==CHAR_SP. The illegal byte is still written to the output RAM before abort.
- Start/latency: start high in IDLE at edge E0 -> RD_SI at E0; DONE at E0+10*N, where N = bytes processed (MSG_LEN, or the aborted index+1).
- start while busy is ignored.
- DONE holds done/valid_msg/abort until reset or start. start in DONE clears the flags, resets i=j=k=0 and begins a new pass; S is not re-initialised by this block.
- valid_msg and abort are never both 1.
- CHECK_EN=0: abort is never asserted; valid_msg=1 at DONE.

Decomposition:
- Package rc4_pkg: state enum type (IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_OUT, NEXT, DONE); default DATA_W; CHAR_LO/CHAR_HI/CHAR_SP constants.
- One sub-module: rc4_char_check, a combinational legality predicate parametrised by DATA_W and the character constants, instantiated once.

Test Plan:
- Identity keystream: S[x]=x, MSG_LEN=3, CHECK_EN=0, ciphertext all 00 -> out 02,05,07; S[2]=03, S[3]=05, S[5]=02; done exactly 30 cycles after start; byte 0 exercises i==j.
- Legal message: identity S, ciphertext 63,64,66, CHECK_EN=1 -> out 61,61,61 ("aaa"); valid_msg=1, abort=0.
- Early abort: identity S, ciphertext 63,00,66 -> byte 1 = 05 is illegal; exactly 2 out_we pulses; abort=1, valid_msg=0; done 20 cycles after start.
- Wrap-around: MSG_LEN=300, random S permutation, random ciphertext, CHECK_EN=0 -> every out byte and the final S match a reference model; i wraps 255->0.
- Control: start pulse mid-run ignored (no extra writes); reset asserted during WR_SI -> next cycle IDLE, all outputs 0; start in DONE restarts with i=j=k=0 and the flags cleared.
